// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and types for the integer datapath.
// Entry 0 of the register file is the architectural zero register.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage : cpu_pkg

// File: rtl/wr_decoder.sv
// One-hot write-enable decoder: the demux counterpart of the read-side selection.
// Bit 0 is tied low so the zero register can never be loaded.
module wr_decoder
    import cpu_pkg::*;
#(
    parameter int N_ADDR  = cpu_pkg::ADDR_W,
    parameter int N_DEPTH = cpu_pkg::DEPTH
) (
    input  logic               en,
    input  logic [N_ADDR-1:0]  addr,
    output logic [N_DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 1; i < N_DEPTH; i++) begin
            onehot[i] = en && (addr == N_ADDR'(i));
        end
    end

endmodule : wr_decoder

// File: rtl/reg_file_2r1w.sv
// 32x32 integer register file, two combinational read ports and one write port,
// with write-first bypass so a WB write is visible to an ID read in the same cycle.
module reg_file_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = cpu_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("reg_file_2r1w: DEPTH must equal 2**ADDR_W");
    end

    logic [DEPTH-1:0]  wen;
    logic [DATA_W-1:0] regs_q   [DEPTH-1:1];
    logic [DATA_W-1:0] regs_view[DEPTH];
    logic              wr_live;
    logic              byp1;
    logic              byp2;

    wr_decoder #(
        .N_ADDR  (ADDR_W),
        .N_DEPTH (DEPTH)
    ) u_wr_decoder (
        .en     (we),
        .addr   (waddr),
        .onehot (wen)
    );

    // An X on we propagates into wen; if (X) takes no branch, so entries hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wen[i]) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        regs_view[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            regs_view[i] = regs_q[i];
        end
    end

    // Bypass is suppressed during reset so reads are 0 even with a write pending.
    always_comb begin
        wr_live = 1'b0;
        if (rst_n && we && (waddr != REG_ZERO)) begin
            wr_live = 1'b1;
        end
        byp1 = wr_live && (waddr == raddr1);
        byp2 = wr_live && (waddr == raddr2);
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rst_n) begin
            if (byp1) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs_view[raddr1];
            end
            if (byp2) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs_view[raddr2];
            end
        end
    end

    we_known_a : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(we))
        else $warning("reg_file_2r1w: we is unknown, write suppressed");

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Directed, table-driven bench for reg_file_2r1w plus hand-written reset sequences.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    int vecCount;
    int missCount;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs[15];

    reg_file_2r1w dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        we     = w;
        waddr  = wa;
        wdata  = wd;
        raddr1 = r1;
        raddr2 = r2;
        #2;
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;

        // {we, waddr, wdata, raddr1, raddr2, exp1, exp2}; expectations are pre-edge
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd4,  32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h11111111, 5'd6,  5'd7,  32'h0,        32'h11111111};
        vecs[5]  = '{1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222, 32'h22222222};
        vecs[6]  = '{1'b0, 5'd7,  32'h33333333, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 5'd3,  32'h0000000A, 5'd1,  5'd2,  32'h0,        32'h0};
        vecs[8]  = '{1'b1, 5'd4,  32'h0000000B, 5'd3,  5'd4,  32'h0000000A, 32'h0000000B};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd3,  32'h0000000B, 32'h0000000A};
        vecs[10] = '{1'b1, 5'd10, 32'h00000001, 5'd10, 5'd9,  32'h00000001, 32'h0};
        vecs[11] = '{1'b1, 5'd10, 32'h00000002, 5'd10, 5'd10, 32'h00000002, 32'h00000002};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd31, 32'h00000002, 32'h0};
        vecs[13] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd31, 32'h0,        32'hCAFEF00D};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  32'hCAFEF00D, 32'h0};

        #12;
        rst_n = 1'b1;

        // Dirty an entry so the asynchronous reset pulse has something to clear
        applyStimulus(1'b1, 5'd5, 32'h00001234, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        checkOutput("prefill_r1", rdata1, 32'h00001234);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkOutput("in_reset_r1", rdata1, 32'h0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            checkOutput($sformatf("reset_all_r1[%0d]", i), rdata1, 32'h0);
            checkOutput($sformatf("reset_all_r2[%0d]", 31 - i), rdata2, 32'h0);
        end

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1, vecs[i].raddr2);
            checkOutput($sformatf("vec%0d_r1", i), rdata1, vecs[i].exp1);
            checkOutput($sformatf("vec%0d_r2", i), rdata2, vecs[i].exp2);
        end

        // Reset lands before the edge of a pending write: the write is lost
        applyStimulus(1'b1, 5'd9, 32'h00000055, 5'd9, 5'd9);
        checkOutput("pre_reset_bypass", rdata1, 32'h00000055);
        rst_n = 1'b0;
        #1 checkOutput("reset_blocks_bypass", rdata2, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
        checkOutput("reset_write_lost_r1", rdata1, 32'h0);
        checkOutput("reset_cleared_r2", rdata2, 32'h0);

        // First edge after reset release performs a write normally
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 5'd12, 32'h00000077, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd31);
        checkOutput("post_release_r1", rdata1, 32'h00000077);
        checkOutput("post_release_r2", rdata2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule : tb_reg_file_2r1w

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Integer register file for the pipelined CPU: 32 entries × 32 bits, two read ports and one write port.
- The write path is a one-hot address decoder plus per-entry load enables. This is the distribution counterpart of the read-side selection muxes.
- Sits between ID (reads) and WB (writes). Provides write-first internal bypass so a WB write and an ID read of the same register in the same cycle need no extra forwarding mux.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, width of the register address.
- DEPTH, 32, number of registers. Must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable from WB stage.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- raddr1  input  ADDR_W  read port 1 index (rs1).
- raddr2  input  ADDR_W  read port 2 index (rs2).
- rdata1  output  DATA_W  read port 1 data.
- rdata2  output  DATA_W  read port 2 data.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: rst_n low clears all DEPTH entries to 0 immediately, independent of clk. rdata1 and rdata2 read 0 while reset is asserted.
- Write: on a rising clk edge with rst_n high, we=1 and waddr!=0, the entry at waddr loads wdata.
  - The decoder produces exactly one enable bit. All other entries hold their value.
  - we=0 changes nothing.
- Entry 0: hardwired zero. Writes to waddr=0 are discarded (its enable is forced low). Reads of index 0 always return 0, including during bypass conditions.
- Read: combinational, zero cycle latency. rdataN = entry[raddrN].
- Bypass (write-first): if we=1, waddr!=0 and waddr==raddrN, then rdataN = wdata in the same cycle, before the edge commits it.
  - Both ports may bypass simultaneously when raddr1==raddr2==waddr.
- Same-cycle write and read of different indices: the read returns the old stored value of its own index.
- Back-to-back writes to the same index: the last edge wins. The intermediate value is visible only via bypass.
- Reset mid-operation: rst_n falling during a cycle with we=1 takes priority. The entry stays 0, and the pending write is lost.
- Reset release: the first rising edge after rst_n goes high may perform a write normally.
- X-safety: an X on we must not corrupt entries in simulation. Treat as no-write and assert a warning.
- No output registers. Entry storage is the only state. Area is DEPTH-1 physical registers.

Decomposition:
- Package cpu_pkg holds:
  - DATA_W = 32 and ADDR_W = 5 constants.
  - typedef reg_addr_t (logic [ADDR_W-1:0]).
  - typedef word_t (logic [DATA_W-1:0]).
  - constant REG_ZERO = 0.
- Sub-module wr_decoder: inputs en and addr, output one-hot enable vector of DEPTH bits, with bit 0 always 0. It is purely combinational and reusable as the generic demux counterpart of mux_2to1.
- Read ports reuse the existing mux structure, or a case/index expression, plus the bypass compare.

Test Plan:
- Reset then read all: pulse rst_n low asynchronously (mid-cycle, not aligned to clk), then read raddr1=0..31 and raddr2=31..0 -> every rdata is 32'h0.
- Basic write/read: we=1, waddr=5, wdata=32'hDEADBEEF, one edge; then we=0, raddr1=5 -> rdata1=32'hDEADBEEF. Also raddr2=6 -> 0, proving only entry 5 was enabled.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF, edge; raddr1=0 -> 0. In the same cycle as that write, raddr2=0 -> 0 (no bypass on x0).
- Bypass: entry 7 holds 32'h11111111. Drive we=1, waddr=7, wdata=32'h22222222, raddr1=7, raddr2=7 -> both rdata = 32'h22222222 before the edge, and stored 32'h22222222 after it.
- Concurrent different indices: entry 3 = 32'hA, write 32'hB to entry 4 while raddr1=3 -> rdata1=32'hA. The next cycle raddr1=4 -> 32'hB.
- Reset during write: we=1, waddr=9, wdata=32'h55, assert rst_n low before the edge, release after -> raddr1=9 reads 0.
